// File: rtl/mdu_if.sv
// Launch/result bundle between the decoder-side issue logic and the iterative
// multiply/divide unit.
interface mdu_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] result;
  logic            done;
  logic            busy;
  logic            stall;

  modport master (
    output start, flush, Funct3, rs1, rs2,
    input  result, done, busy, stall
  );

  modport slave (
    input  start, flush, Funct3, rs1, rs2,
    output result, done, busy, stall
  );
endinterface

// File: rtl/mdu_iterative.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, sign fixed at the end.
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic CLK,
  input  logic rst_n,
  mdu_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONES_X   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return (~v) + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [XLEN-1:0] cond_neg_x(input logic [XLEN-1:0] v, input logic neg);
    return neg ? neg_x(v) : v;
  endfunction

  state_t            state_q, state_d, state_n;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d, result_n;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              done_q, done_d, done_n;
  logic              busy_q, busy_d;

  logic              a_signed_s, b_signed_s, sign_a_s, sign_b_s;
  logic              div_zero_s, ovf_s, accept_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s;
  logic [XLEN:0]     mul_sum_s, div_trial_s;
  logic [2*XLEN-1:0] mul_next_s, div_next_s, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, mul_res_s, div_res_s;

  // Operand classification and magnitude conversion at accept
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    if (bus.Funct3[2]) begin
      a_signed_s = ~bus.Funct3[0];
      b_signed_s = ~bus.Funct3[0];
    end else begin
      a_signed_s = (bus.Funct3[1:0] != 2'b11);
      b_signed_s = ~bus.Funct3[1];
    end
    sign_a_s   = a_signed_s & bus.rs1[XLEN-1];
    sign_b_s   = b_signed_s & bus.rs2[XLEN-1];
    mag_a_s    = cond_neg_x(bus.rs1, sign_a_s);
    mag_b_s    = cond_neg_x(bus.rs2, sign_b_s);
    div_zero_s = (bus.rs2 == ZERO_X);
    ovf_s      = ~bus.Funct3[0] & (bus.rs1 == MIN_NEG) & (bus.rs2 == ONES_X);
    accept_s   = (state_q == S_IDLE) & bus.start & ~bus.flush;
  end

  // One iteration step of each datapath plus the sign-corrected final values.
  // acc holds {hi, lo}: product hi/multiplier for MUL, remainder/quotient for DIV.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    mul_next_s  = {mul_sum_s, acc_q[XLEN-1:1]};
    div_trial_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opb_q};
    if (div_trial_s[XLEN]) begin
      div_next_s = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      div_next_s = {div_trial_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
    prod_s    = (sa_q ^ sb_q) ? neg_2x(mul_next_s) : mul_next_s;
    mul_res_s = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    quo_s     = div_next_s[XLEN-1:0];
    rem_s     = div_next_s[2*XLEN-1:XLEN];
    div_res_s = op_q[1] ? cond_neg_x(rem_s, sa_q) : cond_neg_x(quo_s, sa_q ^ sb_q);
  end

  // Next-state and datapath update; flush overrides everything
  always_comb begin
    state_n  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_n = result_q;
    done_n   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d  = bus.Funct3;
          sa_d  = sign_a_s;
          sb_d  = sign_b_s;
          cnt_d = CNT_ZERO;
          acc_d = {ZERO_X, mag_a_s};
          opb_d = mag_b_s;
          if (bus.Funct3[2] & div_zero_s) begin
            state_n  = S_DONE;
            done_n   = 1'b1;
            result_n = bus.Funct3[1] ? bus.rs1 : ONES_X;
          end else if (bus.Funct3[2] & ovf_s) begin
            state_n  = S_DONE;
            done_n   = 1'b1;
            result_n = bus.Funct3[1] ? ZERO_X : bus.rs1;
          end else begin
            state_n = bus.Funct3[2] ? S_DIV : S_MUL;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        acc_d = (state_q == S_MUL) ? mul_next_s : div_next_s;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_n  = S_DONE;
          done_n   = 1'b1;
          result_n = (state_q == S_MUL) ? mul_res_s : div_res_s;
        end else begin
          state_n = state_q;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    state_d  = bus.flush ? S_IDLE : state_n;
    done_d   = done_n & ~bus.flush;
    result_d = bus.flush ? result_q : result_n;
    busy_d   = (state_d == S_MUL) | (state_d == S_DIV);
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      acc_q    <= {(2*XLEN){1'b0}};
      opb_q    <= ZERO_X;
      op_q     <= 3'b000;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= ZERO_X;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.stall  = accept_s | busy_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Randomized and directed checks of mdu_iterative against a plain-arithmetic
// RV32M model, including latency, stall, flush and async reset behaviour.
module tb_mdu_iterative;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [31:0] last_res;

  mdu_if #(.XLEN(32)) bus ();

  mdu_iterative #(.XLEN(32)) dut (
    .CLK  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint     sa;
    longint     sb;
    longint     ub;
    logic [63:0] p;
    int         q;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ub = longint'({32'h0, b});
    q  = 0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = signed'(a) / signed'(b);
        return q;
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = signed'(a) % signed'(b);
        return q;
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // One complete op: launch, scramble inputs after accept, time the done pulse.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit hold);
    int cyc;
    int exp_lat;
    bit stall_ok;
    exp_lat = (f[2] && (b == 32'h0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
    @(negedge clk);
    bus.start = 1'b1; bus.Funct3 = f; bus.rs1 = a; bus.rs2 = b;
    #1 check_eq({tag, "_stall_c0"}, 32'(bus.stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    if (!hold) bus.start = 1'b0;
    bus.rs1 = $urandom; bus.rs2 = $urandom; bus.Funct3 = 3'($urandom);
    stall_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.stall !== 1'b1 || bus.busy !== 1'b1) stall_ok = 1'b0;
      if (cyc == 16) bus.rs1 = ~bus.rs1;
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_stall_run"}, 32'(stall_ok), 32'd1);
    check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check_eq({tag, "_result"}, bus.result, exp);
    check_eq({tag, "_stall_done"}, 32'(bus.stall), 32'd0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    last_res = exp;
  endtask

  initial begin
    int cyc;
    bit no_done;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    n_tests = 0; n_fail = 0; last_res = 32'h0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.Funct3 = 3'd0; bus.rs1 = 32'h0; bus.rs2 = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_result", bus.result, 32'h0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_stall", 32'(bus.stall), 32'd0);
    rst_n = 1'b1;

    run_op("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
    run_op("div_neg", 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);
    run_op("rem_neg", 3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5, 1'b0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
    run_op("hold_start", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, ref_mdu(3'd3, 32'h1234_5678, 32'h9ABC_DEF0), 1'b1);
    run_op("hold_special", 3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1);

    // start and flush together in IDLE must not launch
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.Funct3 = 3'd0; bus.rs1 = 32'd3; bus.rs2 = 32'd3;
    #1 check_eq("flush_start_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check_eq("flush_start_busy", 32'(bus.busy), 32'd0);

    // flush at cycle 10 of a multiply
    @(negedge clk);
    bus.start = 1'b1; bus.Funct3 = 3'd0; bus.rs1 = 32'd11; bus.rs2 = 32'd13;
    @(negedge clk);
    bus.start = 1'b0;
    for (cyc = 1; cyc < 10; cyc++) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check_eq("flush_busy", 32'(bus.busy), 32'd0);
    check_eq("flush_done", 32'(bus.done), 32'd0);
    check_eq("flush_result", bus.result, last_res);
    no_done = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.done !== 1'b0) no_done = 1'b0;
    end
    check_eq("flush_no_done", 32'(no_done), 32'd1);

    // async reset at cycle 20 of a divide
    @(negedge clk);
    bus.start = 1'b1; bus.Funct3 = 3'd4; bus.rs1 = 32'd1000; bus.rs2 = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    for (cyc = 1; cyc < 20; cyc++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("arst_result", bus.result, 32'h0);
    check_eq("arst_done", 32'(bus.done), 32'd0);
    check_eq("arst_busy", 32'(bus.busy), 32'd0);
    check_eq("arst_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = 32'h0;
    run_op("post_rst", 3'd4, 32'd1000, 32'd3, 32'd333, 1'b0);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, ref_mdu(f, a, b), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
